// File: rtl/phys_free_list_ctrl_if.sv
// Free-list handshake bundle between rename/ROB (master) and the
// physical-register free-list controller (slave).
//   alloc_req / alloc_gnt / alloc_tag : one-tag-per-cycle allocation
//   retire_valid / retire_free_tag    : old mapping released at retirement
//   flush                             : mispredict, discard speculative allocs
interface phys_free_list_ctrl_if #(
  parameter int TAG_W = 6
);
  logic             alloc_req;
  logic             alloc_gnt;
  logic [TAG_W-1:0] alloc_tag;
  logic             retire_valid;
  logic [TAG_W-1:0] retire_free_tag;
  logic             flush;

  modport master (
    output alloc_req, retire_valid, retire_free_tag, flush,
    input  alloc_gnt, alloc_tag
  );

  modport slave (
    input  alloc_req, retire_valid, retire_free_tag, flush,
    output alloc_gnt, alloc_tag
  );
endinterface

// File: rtl/phys_free_list_ctrl.sv
// Physical-register free-list controller.
// Circular list of free tags with a speculative allocation pointer (head),
// a committed allocation pointer (chead) and an insert pointer (tail).
// A flush rolls head back to chead in one cycle, returning every tag taken
// by squashed instructions.
// Ports:
//   CLK, RESET        clock, async active-low reset
//   STALL             blocks the grant only
//   fl (slave)        alloc / retire / flush handshake
//   free_count        speculative free entries (registered)
//   empty             free_count == 0 (registered)
//   overflow_err      sticky: retire seen while list already full
module phys_free_list_ctrl #(
  parameter  int PHYS_REGS = 64,
  parameter  int ARCH_REGS = 32,
  parameter  int TAG_W     = $clog2(PHYS_REGS),
  parameter  int DEPTH     = PHYS_REGS - ARCH_REGS,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 STALL,
  phys_free_list_ctrl_if.slave fl,
  output logic [CNT_W-1:0]     free_count,
  output logic                 empty,
  output logic                 overflow_err
);

  logic [TAG_W-1:0] list [DEPTH];
  logic [PTR_W-1:0] head, chead, tail;
  logic [PTR_W-1:0] head_n, chead_n, tail_n;
  logic [CNT_W-1:0] count, ccount, count_n;
  logic             empty_q;
  logic             gnt, ret_ok, ovf_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant is purely combinational; a tag retired this cycle is only
  // visible next cycle since list[head] reads the registered array.
  assign gnt          = fl.alloc_req & ~empty_q & ~STALL & ~fl.flush;
  assign fl.alloc_gnt = gnt;
  assign fl.alloc_tag = list[head];

  // A retire into a full list is dropped entirely (no pointer moves).
  assign ret_ok  = fl.retire_valid & (count != CNT_W'(DEPTH));
  assign ovf_hit = fl.retire_valid & (count == CNT_W'(DEPTH));

  // Retire, then allocate, then flush: flush sees chead after the retire.
  always_comb begin
    head_n  = head;
    chead_n = chead;
    tail_n  = tail;
    count_n = count;
    if (ret_ok) begin
      tail_n  = ptr_inc(tail);
      chead_n = ptr_inc(chead);
      count_n = count_n + 1'b1;
    end
    if (gnt) begin
      head_n  = ptr_inc(head);
      count_n = count_n - 1'b1;
    end
    if (fl.flush) begin
      head_n  = chead_n;
      count_n = ccount;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) list[i] <= TAG_W'(ARCH_REGS + i);
      head         <= '0;
      chead        <= '0;
      tail         <= '0;
      count        <= CNT_W'(DEPTH);
      ccount       <= CNT_W'(DEPTH);
      empty_q      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (ret_ok) list[tail] <= fl.retire_free_tag;
      head    <= head_n;
      chead   <= chead_n;
      tail    <= tail_n;
      count   <= count_n;
      // One committed entry is consumed and one freed per retire, so the
      // committed count holds its value.
      ccount  <= ccount;
      empty_q <= (count_n == '0);
      if (ovf_hit) overflow_err <= 1'b1;
    end
  end

  assign free_count = count;
  assign empty      = empty_q;

endmodule

// File: tb/tb_phys_free_list_ctrl.sv
module tb_phys_free_list_ctrl;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       STALL = 1'b0;
  logic [5:0] free_count;
  logic       empty, overflow_err;
  int         n_chk = 0;
  int         n_fail = 0;

  phys_free_list_ctrl_if #(.TAG_W(6)) fl_if ();

  phys_free_list_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .STALL        (STALL),
    .fl           (fl_if),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    fl_if.alloc_req       = 1'b0;
    fl_if.retire_valid    = 1'b0;
    fl_if.retire_free_tag = '0;
    fl_if.flush           = 1'b0;
    STALL                 = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    RESET = 1'b0;
    #12;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    clr_in();
    #1;
    // reset values
    RESET = 1'b0;
    #3;
    chk("rst_free", free_count, 32);
    chk("rst_empty", empty, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_gnt", fl_if.alloc_gnt, 0);
    @(negedge CLK);
    RESET = 1'b1;

    // three consecutive grants
    fl_if.alloc_req = 1'b1; #1;
    chk("t1_gnt0", fl_if.alloc_gnt, 1);
    chk("t1_tag0", fl_if.alloc_tag, 32);
    step(); chk("t1_tag1", fl_if.alloc_tag, 33);
    step(); chk("t1_tag2", fl_if.alloc_tag, 34);
    step(); fl_if.alloc_req = 1'b0; #1;
    chk("t1_free", free_count, 29);
    chk("t1_gnt_idle", fl_if.alloc_gnt, 0);

    // drain to empty, then a retire refills one slot (no bypass)
    fl_if.alloc_req = 1'b1;
    repeat (29) step();
    chk("t2_empty", empty, 1);
    chk("t2_free", free_count, 0);
    chk("t2_gnt_empty", fl_if.alloc_gnt, 0);
    fl_if.retire_valid = 1'b1; fl_if.retire_free_tag = 6'd5; #1;
    chk("t2_no_bypass", fl_if.alloc_gnt, 0);
    step(); fl_if.retire_valid = 1'b0; #1;
    chk("t2_free1", free_count, 1);
    chk("t2_gnt5", fl_if.alloc_gnt, 1);
    chk("t2_tag5", fl_if.alloc_tag, 5);
    step(); fl_if.alloc_req = 1'b0; #1;
    chk("t2_empty2", empty, 1);

    // alloc 4, retire 1, flush, then walk to the wrapped tail
    do_reset();
    fl_if.alloc_req = 1'b1; #1;
    chk("t3_tag32", fl_if.alloc_tag, 32);
    step(); chk("t3_tag33", fl_if.alloc_tag, 33);
    step(); chk("t3_tag34", fl_if.alloc_tag, 34);
    step(); chk("t3_tag35", fl_if.alloc_tag, 35);
    step(); fl_if.alloc_req = 1'b0;
    fl_if.retire_valid = 1'b1; fl_if.retire_free_tag = 6'd7;
    step(); fl_if.retire_valid = 1'b0; #1;
    chk("t3_free_pre", free_count, 29);
    fl_if.alloc_req = 1'b1; fl_if.flush = 1'b1; #1;
    chk("t3_gnt_flush", fl_if.alloc_gnt, 0);
    step(); fl_if.flush = 1'b0; #1;
    chk("t3_free_flush", free_count, 32);
    chk("t3_re33", fl_if.alloc_tag, 33);
    step(); chk("t3_re34", fl_if.alloc_tag, 34);
    step(); chk("t3_re35", fl_if.alloc_tag, 35);
    repeat (29) step();
    chk("t3_wrap_gnt", fl_if.alloc_gnt, 1);
    chk("t3_wrap_tag7", fl_if.alloc_tag, 7);
    step(); fl_if.alloc_req = 1'b0; #1;
    chk("t3_free_end", free_count, 0);

    // alloc + retire + flush in one cycle
    do_reset();
    fl_if.alloc_req = 1'b1;
    step(); step(); fl_if.alloc_req = 1'b0;
    fl_if.retire_valid = 1'b1; fl_if.retire_free_tag = 6'd20;
    step(); fl_if.retire_valid = 1'b0; #1;
    chk("t4_free31", free_count, 31);
    fl_if.alloc_req = 1'b1; fl_if.retire_valid = 1'b1;
    fl_if.retire_free_tag = 6'd9; fl_if.flush = 1'b1; #1;
    chk("t4_gnt_flush", fl_if.alloc_gnt, 0);
    step(); fl_if.retire_valid = 1'b0; fl_if.flush = 1'b0; #1;
    chk("t4_free32", free_count, 32);
    chk("t4_ovf", overflow_err, 0);
    chk("t4_head_tag", fl_if.alloc_tag, 34);
    fl_if.alloc_req = 1'b0;

    // STALL blocks grant but not retire
    do_reset();
    fl_if.alloc_req = 1'b1;
    repeat (3) step();
    STALL = 1'b1; fl_if.retire_valid = 1'b1; fl_if.retire_free_tag = 6'd40; #1;
    chk("t5_stall_gnt0", fl_if.alloc_gnt, 0);
    step(); fl_if.retire_free_tag = 6'd41; #1;
    chk("t5_stall_gnt1", fl_if.alloc_gnt, 0);
    step(); fl_if.retire_valid = 1'b0; #1;
    chk("t5_free31", free_count, 31);
    STALL = 1'b0; #1;
    chk("t5_gnt", fl_if.alloc_gnt, 1);
    chk("t5_tag35", fl_if.alloc_tag, 35);
    fl_if.alloc_req = 1'b0;

    // overflow, stickiness, async reset mid-sequence
    do_reset();
    fl_if.retire_valid = 1'b1; fl_if.retire_free_tag = 6'd12;
    step(); fl_if.retire_valid = 1'b0; #1;
    chk("t6_ovf", overflow_err, 1);
    chk("t6_free32", free_count, 32);
    fl_if.alloc_req = 1'b1; #1;
    chk("t6_list_kept", fl_if.alloc_tag, 32);
    step(); fl_if.alloc_req = 1'b0; #1;
    chk("t6_ovf_sticky", overflow_err, 1);
    chk("t6_free31", free_count, 31);
    fl_if.retire_valid = 1'b1; fl_if.retire_free_tag = 6'd13; fl_if.flush = 1'b1;
    @(posedge CLK); #3;
    RESET = 1'b0; #1;
    chk("t6_arst_free", free_count, 32);
    chk("t6_arst_ovf", overflow_err, 0);
    chk("t6_arst_empty", empty, 0);
    chk("t6_arst_tag", fl_if.alloc_tag, 32);
    chk("t6_arst_gnt", fl_if.alloc_gnt, 0);
    do_reset();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
